// File: rtl/arb_escritura_reg_pkg.sv
// Shared constants for the register-bank write arbiter: default widths,
// the $zero register address and the fixed requester slots.
package arb_escritura_reg_pkg;

   localparam int ANCHO_DATO = 32;
   localparam int ANCHO_DIR  = 5;

   // Writes to this address are accepted but never reach the bank.
   localparam logic [4:0] DIR_CERO = 5'd0;

   // Requester slots: ALU result and memory load.
   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;

endpackage

// File: rtl/arb_escritura_reg_rr_prioridad.sv
// Rotating-priority encoder: starting at i_ptr and wrapping modulo NUM_REQ,
// the first requester with i_req set wins. Purely combinational.
module rr_prioridad #(
   parameter int NUM_REQ   = 2,
   parameter int ANCHO_PTR = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [ANCHO_PTR-1:0] i_ptr,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [ANCHO_PTR-1:0] o_win,
   output logic                 o_any_valid
);

   // Walk the requesters in priority order from i_ptr; the first hit is latched.
   always_comb begin
      int                   w_idx;
      logic [ANCHO_PTR-1:0] w_sel;
      logic                 w_hallado;
      w_idx       = 0;
      w_sel       = '0;
      w_hallado   = 1'b0;
      o_grant     = '0;
      o_win       = '0;
      o_any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         w_sel = w_idx[ANCHO_PTR-1:0];
         if (!w_hallado && i_req[w_sel]) begin
            w_hallado      = 1'b1;
            o_grant[w_sel] = 1'b1;
            o_win          = w_sel;
         end
      end
      o_any_valid = w_hallado;
   end

endmodule

// File: rtl/arb_escritura_reg.sv
// Write-port arbiter for the 32x32 register bank. Round-robin among NUM_REQ
// write-back sources; the winning write is registered and presented to the
// bank for exactly one cycle.
//
// Handshake: requester i holds req_valid[i] and its dir/dato stable until it
// sees req_ready[i]=1 at a rising edge; that edge is the accept. req_ready
// never depends on the chosen requester's dir/dato, and at most one bit of
// req_ready is set in a cycle. Stall or reset forces req_ready to zero.
module arb_escritura_reg #(
   parameter int NUM_REQ    = 2,
   parameter int ANCHO_DATO = arb_escritura_reg_pkg::ANCHO_DATO,
   parameter int ANCHO_DIR  = arb_escritura_reg_pkg::ANCHO_DIR
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ANCHO_DIR-1:0]  req_dir,
   input  logic [NUM_REQ*ANCHO_DATO-1:0] req_dato,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          RWEN,
   output logic [ANCHO_DIR-1:0]          DirWrite,
   output logic [ANCHO_DATO-1:0]         DatoNuevo,
   output logic [ANCHO_DIR-1:0]          dir_pendiente,
   output logic                          pendiente
);

   import arb_escritura_reg_pkg::*;

   localparam int ANCHO_PTR = $clog2(NUM_REQ);

   logic [ANCHO_PTR-1:0]  r_ptr;
   logic                  r_rwen;
   logic [ANCHO_DIR-1:0]  r_dir;
   logic [ANCHO_DATO-1:0] r_dato;

   logic [NUM_REQ-1:0]    w_grant;
   logic [ANCHO_PTR-1:0]  w_win;
   logic [ANCHO_PTR-1:0]  w_ptr_sig;
   logic                  w_any_valid;
   logic                  w_habilita;
   logic                  w_accept;
   logic                  w_es_cero;
   logic [ANCHO_DIR-1:0]  w_dir_win;
   logic [ANCHO_DATO-1:0] w_dato_win;

   rr_prioridad #(
      .NUM_REQ   (NUM_REQ),
      .ANCHO_PTR (ANCHO_PTR)
   ) u_rr_prioridad (
      .i_req       (req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_win       (w_win),
      .o_any_valid (w_any_valid)
   );

   // Reset dominates stall; either one blocks every accept this cycle.
   assign w_habilita = ~stall & ~rst;
   assign req_ready  = w_grant & {NUM_REQ{w_habilita}};
   assign w_accept   = w_any_valid & w_habilita;

   assign w_dir_win  = req_dir[w_win*ANCHO_DIR +: ANCHO_DIR];
   assign w_dato_win = req_dato[w_win*ANCHO_DATO +: ANCHO_DATO];
   assign w_es_cero  = (w_dir_win == ANCHO_DIR'(DIR_CERO));

   // Next pointer is the slot after the winner, wrapping at NUM_REQ.
   assign w_ptr_sig = (w_win == ANCHO_PTR'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

   // Pointer and output register stage; $zero writes advance the pointer only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr  <= '0;
         r_rwen <= 1'b0;
         r_dir  <= '0;
         r_dato <= '0;
      end else if (w_accept) begin
         r_ptr <= w_ptr_sig;
         if (!w_es_cero) begin
            r_rwen <= 1'b1;
            r_dir  <= w_dir_win;
            r_dato <= w_dato_win;
         end else begin
            r_rwen <= 1'b0;
         end
      end else begin
         r_rwen <= 1'b0;
      end
   end

   assign RWEN          = r_rwen;
   assign DirWrite      = r_dir;
   assign DatoNuevo     = r_dato;
   assign pendiente     = r_rwen;
   assign dir_pendiente = r_dir;

endmodule

// File: tb/tb_arb_escritura_reg.sv
// Directed bench for the register-bank write arbiter (two requesters).
module tb_arb_escritura_reg;

   import arb_escritura_reg_pkg::*;

   localparam int N  = 2;
   localparam int WD = 32;
   localparam int WA = 5;

   logic            clk;
   logic            rst;
   logic            stall;
   logic [N-1:0]    req_valid;
   logic [N*WA-1:0] req_dir;
   logic [N*WD-1:0] req_dato;
   logic [N-1:0]    req_ready;
   logic            RWEN;
   logic [WA-1:0]   DirWrite;
   logic [WD-1:0]   DatoNuevo;
   logic [WA-1:0]   dir_pendiente;
   logic            pendiente;

   int n_tests;
   int n_fail;

   arb_escritura_reg #(
      .NUM_REQ    (N),
      .ANCHO_DATO (WD),
      .ANCHO_DIR  (WA)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .req_valid     (req_valid),
      .req_dir       (req_dir),
      .req_dato      (req_dato),
      .req_ready     (req_ready),
      .RWEN          (RWEN),
      .DirWrite      (DirWrite),
      .DatoNuevo     (DatoNuevo),
      .dir_pendiente (dir_pendiente),
      .pendiente     (pendiente)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Driver helpers
   task automatic set_req(input int i, input logic v, input logic [WA-1:0] d,
                          input logic [WD-1:0] x);
      req_valid[i]           = v;
      req_dir[i*WA +: WA]    = d;
      req_dato[i*WD +: WD]   = x;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(REQ_ALU, 1'b1, 5'd3, 32'd30);
      set_req(REQ_MEM, 1'b1, 5'd4, 32'd40);
      for (int c = 0; c < 2; c++) begin
         step();
         n_tests++;
         if ({req_ready, RWEN, DirWrite, DatoNuevo} !== {2'b00, 1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got ready=%b rwen=%b dir=%0d dato=%h, expected all zero",
                     c, req_ready, RWEN, DirWrite, DatoNuevo);
         end
      end
      step();
      rst = 1'b0;
      req_valid = '0;
      #1;
      n_tests++;
      if ({req_ready, RWEN, pendiente} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_after: got ready=%b rwen=%b pend=%b, expected 0", req_ready, RWEN, pendiente);
      end
      step();
      n_tests++;
      if (RWEN !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got rwen=%b expected 0", RWEN);
      end
   endtask

   // ptr = 0 on entry, 1 on exit
   task automatic test_single();
      step();
      set_req(REQ_ALU, 1'b1, 5'd5, 32'd10);
      set_req(REQ_MEM, 1'b0, 5'd0, 32'd0);
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL single_ready: got %b expected 01", req_ready);
      end
      step();
      set_req(REQ_ALU, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo, pendiente, dir_pendiente} !== {1'b1, 5'd5, 32'd10, 1'b1, 5'd5}) begin
         n_fail++;
         $display("FAIL single_write: got rwen=%b dir=%0d dato=%0d pend=%b dirp=%0d, expected 1/5/10/1/5",
                  RWEN, DirWrite, DatoNuevo, pendiente, dir_pendiente);
      end
      step();
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b0, 5'd5, 32'd10}) begin
         n_fail++;
         $display("FAIL single_oneshot: got rwen=%b dir=%0d dato=%0d, expected 0/5/10", RWEN, DirWrite, DatoNuevo);
      end
   endtask

   // ptr = 1 on entry, 0 on exit
   task automatic test_zero();
      step();
      set_req(REQ_MEM, 1'b1, 5'd0, 32'hFFFF);
      #1;
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_ready: got %b expected 10", req_ready);
      end
      step();
      set_req(REQ_ALU, 1'b1, 5'd3, 32'd33);
      set_req(REQ_MEM, 1'b1, 5'd9, 32'd3);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b0, 5'd5, 32'd10}) begin
         n_fail++;
         $display("FAIL zero_nowrite: got rwen=%b dir=%0d dato=%h, expected 0/5/a", RWEN, DirWrite, DatoNuevo);
      end
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL zero_ptr_adv: got ready=%b expected 01", req_ready);
      end
      step();
      set_req(REQ_ALU, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd3, 32'd33}) begin
         n_fail++;
         $display("FAIL zero_next_alu: got rwen=%b dir=%0d dato=%0d, expected 1/3/33", RWEN, DirWrite, DatoNuevo);
      end
      #1;
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_next_ready: got %b expected 10", req_ready);
      end
      step();
      set_req(REQ_MEM, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd9, 32'd3}) begin
         n_fail++;
         $display("FAIL zero_next_mem: got rwen=%b dir=%0d dato=%0d, expected 1/9/3", RWEN, DirWrite, DatoNuevo);
      end
   endtask

   // ptr = 0 on entry; a req0 write moves it to 1 before the stall; 1 on exit
   task automatic test_stall();
      step();
      set_req(REQ_ALU, 1'b1, 5'd4, 32'd44);
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_pre_ready: got %b expected 01", req_ready);
      end
      step();
      stall = 1'b1;
      set_req(REQ_ALU, 1'b1, 5'd6, 32'd60);
      set_req(REQ_MEM, 1'b1, 5'd11, 32'd110);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd4, 32'd44}) begin
         n_fail++;
         $display("FAIL stall_inflight: got rwen=%b dir=%0d dato=%0d, expected 1/4/44", RWEN, DirWrite, DatoNuevo);
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_ready[%0d]: got %b expected 00", c, req_ready);
         end
         step();
         if (c == 2) stall = 1'b0;
         n_tests++;
         if (RWEN !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_rwen[%0d]: got %b expected 0", c, RWEN);
         end
      end
      #1;
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_resume_ptr: got %b expected 10", req_ready);
      end
      step();
      set_req(REQ_MEM, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd11, 32'd110}) begin
         n_fail++;
         $display("FAIL stall_resume_w1: got rwen=%b dir=%0d dato=%0d, expected 1/11/110", RWEN, DirWrite, DatoNuevo);
      end
      step();
      set_req(REQ_ALU, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd6, 32'd60}) begin
         n_fail++;
         $display("FAIL stall_resume_w2: got rwen=%b dir=%0d dato=%0d, expected 1/6/60", RWEN, DirWrite, DatoNuevo);
      end
   endtask

   // ptr = 1 on entry; reset forces it to 0; 0 on exit. Stall is also
   // raised with reset to show reset dominates.
   task automatic test_reset_mid();
      step();
      rst   = 1'b1;
      stall = 1'b1;
      set_req(REQ_ALU, 1'b1, 5'd12, 32'd1);
      #1;
      n_tests++;
      if (req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_ready: got %b expected 00", req_ready);
      end
      step();
      rst   = 1'b0;
      stall = 1'b0;
      set_req(REQ_MEM, 1'b1, 5'd13, 32'd2);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b0, 5'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL rstmid_regs: got rwen=%b dir=%0d dato=%0d, expected 0/0/0", RWEN, DirWrite, DatoNuevo);
      end
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL rstmid_ptr0: got %b expected 01", req_ready);
      end
      step();
      set_req(REQ_ALU, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd12, 32'd1}) begin
         n_fail++;
         $display("FAIL rstmid_w1: got rwen=%b dir=%0d dato=%0d, expected 1/12/1", RWEN, DirWrite, DatoNuevo);
      end
      step();
      set_req(REQ_MEM, 1'b0, 5'd0, 32'd0);
      n_tests++;
      if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, 5'd13, 32'd2}) begin
         n_fail++;
         $display("FAIL rstmid_w2: got rwen=%b dir=%0d dato=%0d, expected 1/13/2", RWEN, DirWrite, DatoNuevo);
      end
   endtask

   // ptr = 0 on entry; both requesters stay valid, so writes alternate.
   task automatic test_round_robin();
      logic [WA-1:0] exp_dir [4];
      logic [WD-1:0] exp_dato[4];
      logic [N-1:0]  exp_rdy [4];
      logic [N-1:0]  rdy_prev;
      exp_dir  = '{5'd7, 5'd8, 5'd7, 5'd8};
      exp_dato = '{32'd20, 32'd25, 32'd20, 32'd25};
      exp_rdy  = '{2'b10, 2'b01, 2'b10, 2'b01};
      step();
      set_req(REQ_ALU, 1'b1, 5'd7, 32'd20);
      set_req(REQ_MEM, 1'b1, 5'd8, 32'd25);
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL rr_first: got %b expected 01", req_ready);
      end
      rdy_prev = req_ready;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++;
         if ({RWEN, DirWrite, DatoNuevo} !== {1'b1, exp_dir[i], exp_dato[i]}) begin
            n_fail++;
            $display("FAIL rr_write[%0d]: got rwen=%b dir=%0d dato=%0d, expected 1/%0d/%0d",
                     i, RWEN, DirWrite, DatoNuevo, exp_dir[i], exp_dato[i]);
         end
         n_tests++;
         if (req_ready !== exp_rdy[i] || req_ready === rdy_prev) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got %b expected %b (previous %b)", i, req_ready, exp_rdy[i], rdy_prev);
         end
         rdy_prev = req_ready;
      end
      req_valid = '0;
      step();
      n_tests++;
      if (RWEN !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_idle: got rwen=%b expected 0", RWEN);
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      stall     = 1'b0;
      req_valid = '0;
      req_dir   = '0;
      req_dato  = '0;
      test_reset();
      test_single();
      test_zero();
      test_stall();
      test_reset_mid();
      test_round_robin();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
